// File: rtl/stallable_pipeline_subtractor.sv
// stallable_pipeline_subtractor: stallable multi-stage ripple-borrow subtractor
module stallable_pipeline_subtractor #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] cin_a,
    input  logic [WIDTH-1:0] cin_b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             valid_out
);
    localparam int SL = WIDTH / STAGES;

    // Stage s resolves bits [(s+1)*SL-1:s*SL]; only the still-unresolved upper
    // operand slices travel forward, and the resolved low diff bits accumulate.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int R = WIDTH - s * SL;
        logic [R-1:0]          a_i, b_i;
        logic                  br_i, v_i;
        logic [SL:0]           sl;
        logic [(s+1)*SL-1:0]   d_n, d_q;
        logic                  br_q, v_q;
        if (s == 0) begin : g_src
            assign a_i  = cin_a;
            assign b_i  = cin_b;
            assign br_i = b_in;
            assign v_i  = valid_in;
            assign d_n  = sl[SL-1:0];
        end else begin : g_src
            assign a_i  = g_stage[s-1].g_fwd.a_q;
            assign b_i  = g_stage[s-1].g_fwd.b_q;
            assign br_i = g_stage[s-1].br_q;
            assign v_i  = g_stage[s-1].v_q;
            assign d_n  = {sl[SL-1:0], g_stage[s-1].d_q};
        end
        // Slice subtract with one extra bit: the top bit is the slice borrow.
        always_comb
            sl = {1'b0, a_i[SL-1:0]} - {1'b0, b_i[SL-1:0]} - (SL+1)'(br_i);
        // Stage result, borrow and valid: cleared on reset, frozen on stall.
        always_ff @(posedge clk)
            if (rst) begin
                d_q  <= '0;
                br_q <= 1'b0;
                v_q  <= 1'b0;
            end else if (!stop) begin
                d_q  <= d_n;
                br_q <= sl[SL];
                v_q  <= v_i;
            end
        if (s < STAGES - 1) begin : g_fwd
            logic [R-SL-1:0] a_q, b_q;
            // Forward the operand slices later stages still need.
            always_ff @(posedge clk)
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stop) begin
                    a_q <= a_i[R-1:SL];
                    b_q <= b_i[R-1:SL];
                end
        end
    end

    assign diff      = g_stage[STAGES-1].d_q;
    assign b_out     = g_stage[STAGES-1].br_q;
    assign valid_out = g_stage[STAGES-1].v_q;
endmodule

// File: tb/tb_stallable_pipeline_subtractor.sv
// tb_stallable_pipeline_subtractor: scoreboard bench for the stallable subtractor
module tb_stallable_pipeline_subtractor;
    localparam int STAGES = 4;

    typedef struct {
        logic [7:0] d;
        logic       b;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stop = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] cin_a = '0;
    logic [7:0] cin_b = '0;
    logic       b_in = 1'b0;
    logic [7:0] diff;
    logic       b_out;
    logic       valid_out;

    logic [7:0] exp_d = '0;
    logic       exp_b = 1'b0;
    exp_t       q[$];
    int         adv = 0;
    bit         adv_last = 0;
    int         checks = 0;
    int         errors = 0;

    stallable_pipeline_subtractor #(.WIDTH(8), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .stop(stop), .valid_in(valid_in),
        .cin_a(cin_a), .cin_b(cin_b), .b_in(b_in),
        .diff(diff), .b_out(b_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // Issue side: record what each advancing edge accepts and when it is due.
    always @(posedge clk) begin
        adv_last = 0;
        if (rst)
            q.delete();
        else if (!stop) begin
            adv++;
            adv_last = 1;
            if (valid_in)
                q.push_back('{exp_d, exp_b, adv + STAGES - 1});
        end
    end

    // Monitor: after every advancing edge compare whatever the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (adv_last) begin
            if (valid_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got diff=%h b_out=%b at edge %0d, required no valid result",
                             diff, b_out, adv);
                end else begin
                    e = q.pop_front();
                    if (diff !== e.d || b_out !== e.b || adv != e.due) begin
                        errors++;
                        $display("FAIL result: got diff=%h b_out=%b edge=%0d, required diff=%h b_out=%b edge=%0d",
                                 diff, b_out, adv, e.d, e.b, e.due);
                    end
                end
            end else if (q.size() != 0 && q[0].due <= adv) begin
                checks++;
                errors++;
                $display("FAIL missing_result: got valid_out=0 at edge %0d, required diff=%h b_out=%b",
                         adv, q[0].d, q[0].b);
                void'(q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic bi, input logic [7:0] ed, input logic eb);
        @(negedge clk);
        rst = r; stop = s; valid_in = v;
        cin_a = a; cin_b = b; b_in = bi;
        exp_d = ed; exp_b = eb;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic chk_out(input string name, input logic [7:0] d, input logic b, input logic v);
        @(posedge clk);
        #1;
        chk({name, "_diff"}, {1'b0, diff}, {1'b0, d});
        chk({name, "_b_out"}, {8'h00, b_out}, {8'h00, b});
        chk({name, "_valid"}, {8'h00, valid_out}, {8'h00, v});
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] a, b;
        logic       bi, v, s, rs;
        step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        chk_out("reset", 8'h00, 0, 0);
        // basic
        step(0, 0, 1, 8'h05, 8'h03, 0, 8'h02, 0);
        idle(6);
        // wrap and borrow
        step(0, 0, 1, 8'h00, 8'h01, 0, 8'hFF, 1);
        step(0, 0, 1, 8'h80, 8'h01, 1, 8'h7E, 0);
        step(0, 0, 1, 8'h00, 8'hFF, 1, 8'h00, 1);
        idle(6);
        // adder inverse stream
        step(0, 0, 1, 8'h01, 8'h01, 0, 8'h00, 0);
        step(0, 0, 1, 8'h09, 8'h01, 1, 8'h07, 0);
        step(0, 0, 1, 8'h42, 8'h01, 1, 8'h40, 0);
        step(0, 0, 1, 8'h82, 8'h01, 0, 8'h81, 0);
        idle(6);
        // stall with a full pipeline; garbage offered during the stall is ignored
        step(0, 0, 1, 8'h10, 8'h03, 0, 8'h0D, 0);
        step(0, 0, 1, 8'h20, 8'h05, 1, 8'h1A, 0);
        step(0, 0, 1, 8'h30, 8'h31, 0, 8'hFF, 1);
        step(0, 0, 1, 8'h40, 8'h01, 0, 8'h3F, 0);
        step(0, 1, 1, 8'hAA, 8'h55, 1, 8'h00, 0);
        chk_out("stall1", 8'h0D, 0, 1);
        step(0, 1, 1, 8'h13, 8'hC4, 0, 8'h00, 0);
        chk_out("stall2", 8'h0D, 0, 1);
        step(0, 0, 1, 8'h77, 8'h77, 1, 8'hFF, 1);
        idle(6);
        // reset mid-stream, asserted together with stop
        step(0, 0, 1, 8'h11, 8'h22, 0, 8'hEF, 1);
        step(0, 0, 1, 8'h33, 8'h01, 0, 8'h32, 0);
        step(0, 0, 1, 8'h44, 8'h45, 1, 8'hFE, 1);
        step(1, 1, 1, 8'h55, 8'h01, 0, 8'h54, 0);
        chk_out("midreset", 8'h00, 0, 0);
        idle(6);
        step(0, 0, 1, 8'h90, 8'h01, 1, 8'h8E, 0);
        idle(6);
        // random
        for (int i = 0; i < 1000; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 49) == 0);
            r  = {1'b0, a} - {1'b0, b} - 9'(bi);
            step(rs, s, v, a, b, bi, r[7:0], r[8]);
        end
        idle(8);
        chk("drain_empty", 9'(q.size()), 9'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stallable_pipeline_subtractor.md
Name: stallable_pipeline_subtractor

Overview:
Stallable multi-stage ripple-borrow subtractor. Computes diff = cin_a - cin_b - b_in and produces borrow-out b_out. It is the inverse companion of stallable_pipeline_adder: feeding it the adder's sum, the same cin_b and the same carry-in recovers the adder's original cin_a. It sits on the same stall (stop) and reset network as the adder, so the two pipelines can be frozen and cleared together.

Parameters:
WIDTH, 8, operand/result width in bits.
STAGES, 4, pipeline depth. WIDTH must be divisible by STAGES; each stage resolves WIDTH/STAGES bits.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high.
stop  input  1  stall; when high, every pipeline register holds its value.
valid_in  input  1  marks cin_a/cin_b/b_in as a real operation.
cin_a  input  WIDTH  minuend.
cin_b  input  WIDTH  subtrahend.
b_in  input  1  borrow-in; 1 subtracts an extra 1.
diff  output  WIDTH  registered result, low WIDTH bits of cin_a - cin_b - b_in.
b_out  output  1  registered borrow-out; 1 when cin_a < cin_b + b_in (unsigned).
valid_out  output  1  diff/b_out belong to a valid_in=1 operation.

Behaviour:
- Reset: on a posedge with rst=1, all stage registers clear. This includes partial diffs, forwarded operand slices, inter-stage borrows and valid bits. diff=0, b_out=0 and valid_out=0 from that edge on. rst has priority over stop. Operands sampled on the reset edge are discarded.
- Capture: on a posedge with rst=0 and stop=0, stage 1 samples cin_a, cin_b, b_in and valid_in. It computes bits [WIDTH/STAGES-1:0] and its stage borrow, and carries the unresolved upper operand slices forward.
- Stage k (k>1): on the same advancing edge, it takes stage k-1's borrow and resolves bits [k*W/S-1:(k-1)*W/S]. Already-resolved low bits pass through unchanged.
- Outputs: diff, b_out and valid_out are stage STAGES's registers; there is no extra output register.
- Latency: exactly STAGES advancing edges (4 by default). An operand sampled at edge N appears at the outputs after edge N+3, counting only non-stalled edges.
- Throughput: one operation per non-stalled cycle, with back-to-back issue.
- Stall: on a posedge with stop=1 (and rst=0), no register changes. Outputs hold, and inputs presented during the stall are not sampled. A producer must hold its operand until stop drops; the operand present on the first edge with stop=0 is the one taken.
- Bubbles: valid_in=0 still advances the pipeline and computes on whatever data is present, but valid_out=0 for that slot. Consumers must ignore diff/b_out when valid_out=0.
- Arithmetic: unsigned modulo 2^WIDTH. The borrow chain is exact across stage boundaries. The result must equal the combinational {b_out,diff} = {1'b0,cin_a} - {1'b0,cin_b} - b_in for every input.
- Wrap: 0x00-0x01-0 -> diff 0xFF, b_out 1. 0x00-0xFF-1 -> diff 0x00, b_out 1.
- Reset mid-stream: all in-flight operations are lost. The first valid result after reset appears STAGES advancing edges after the first valid sample.
- Simultaneous stop and rst: reset wins.
- stop deasserting: the pipeline resumes in place with no duplicated or dropped in-flight results.

Test Plan:
- Basic: a=0x05, b=0x03, b_in=0, valid_in=1 on one edge -> after 4 edges diff=0x02, b_out=0, valid_out=1; valid_out=0 the following edge if valid_in then 0.
- Wrap/borrow: a=0x00, b=0x01, b_in=0 -> diff=0xFF, b_out=1. a=0x80, b=0x01, b_in=1 -> diff=0x7E, b_out=0.
- Adder inverse: stream (a,b,b_in) = (0x01,0x01,0), (0x09,0x01,1), (0x42,0x01,1), (0x82,0x01,0) back-to-back -> diffs 0x00, 0x07, 0x40, 0x81 on four consecutive edges, starting 4 edges after the first sample.
- Stall: while streaming, hold stop=1 for 2 edges with operands held -> outputs frozen for those 2 edges. The sequence then resumes with no gap, duplicate or lost result; total latency becomes 4+2 edges for in-flight items.
- Reset mid-stream: assert rst for one edge with 3 operations in flight -> diff=0, b_out=0, valid_out=0 after that edge. None of the flushed results ever appears. A new op (0x90, 0x01, 1) yields diff=0x8E, b_out=0 4 edges later.
- Random: 1000 random (a, b, b_in, valid_in, stop) vectors against a queue-based reference model -> exact match on every valid_out=1 cycle, and rst/stop priority checked.
